// File: rtl/snf_txrsp_arb.sv
// snf_txrsp_arb: CHI-E TX RSP link-layer sender with L-credit gating and a deactivation credit-return sequence.
// Optional build macro SNF_TXRSP_RR_EN selects round-robin source arbitration (fixed priority when undefined).
`ifndef CHIE_RSP_FLIT_WIDTH
`define CHIE_RSP_FLIT_WIDTH 73
`endif
`ifndef CHIE_RESPLCRDRETURN
`define CHIE_RESPLCRDRETURN 5'h00
`endif

module snf_txrsp_arb #(
    parameter int NUM_SRC       = 3,
    parameter int CRD_MAX       = 15,
    parameter int CRD_CNT_WIDTH = 4,
    parameter int SNF_NID_PARAM = 0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   txrsp_link_active,
    input  logic                                   txrsp_lcrdv,
    input  logic [NUM_SRC-1:0]                     src_valid,
    input  logic [NUM_SRC*`CHIE_RSP_FLIT_WIDTH-1:0] src_flit,
    output logic [NUM_SRC-1:0]                     src_won,
    output logic                                   txrspflitv,
    output logic [`CHIE_RSP_FLIT_WIDTH-1:0]        txrspflit,
    output logic                                   txrspflitpend,
    output logic                                   txrsp_stopped,
    output logic                                   txrsp_crd_ovf
);

    localparam int FW         = `CHIE_RSP_FLIT_WIDTH;
    localparam int SRCID_LSB  = 15;
    localparam int SRCID_W    = 11;
    localparam int OPCODE_LSB = 38;
    localparam int OPCODE_W   = 5;
    localparam int IDX_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [CRD_CNT_WIDTH-1:0] CNT_MAX = CRD_CNT_WIDTH'(CRD_MAX);

    typedef enum logic [1:0] {
        ST_STOP   = 2'd0,
        ST_RUN    = 2'd1,
        ST_RETURN = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [CRD_CNT_WIDTH-1:0] cnt;
    logic                     crd_avail;
    logic                     grant_en;
    logic                     ret_send;
    logic                     flit_sent;
    logic                     sel_found;
    logic [IDX_W-1:0]         sel_idx;
    logic [FW-1:0]            ret_flit;

    // A credit arriving this cycle can pay for a flit in the same cycle.
    assign crd_avail     = txrsp_lcrdv | (cnt != '0);
    assign flit_sent     = grant_en | ret_send;
    assign txrspflitpend = 1'b1;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_STOP;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_STOP: begin
                if (txrsp_link_active) begin
                    state_nxt = ST_RUN;
                end else if (txrsp_lcrdv) begin
                    state_nxt = ST_RETURN;
                end
            end
            ST_RUN: begin
                if (!txrsp_link_active) begin
                    state_nxt = ST_RETURN;
                end
            end
            ST_RETURN: begin
                // link_active is deliberately ignored until every credit is handed back.
                if ((cnt == '0) && !txrsp_lcrdv) begin
                    state_nxt = ST_STOP;
                end
            end
            default: state_nxt = ST_STOP;
        endcase
    end

    always_comb begin
        grant_en      = 1'b0;
        ret_send      = 1'b0;
        txrsp_stopped = 1'b0;
        src_won       = '0;
        unique case (state)
            ST_STOP:   txrsp_stopped = 1'b1;
            ST_RUN:    grant_en = txrsp_link_active & crd_avail & sel_found;
            ST_RETURN: ret_send = crd_avail;
            default:   txrsp_stopped = 1'b0;
        endcase
        if (grant_en) begin
            src_won[sel_idx] = 1'b1;
        end
    end

`ifdef SNF_TXRSP_RR_EN
    logic [IDX_W-1:0] rr_ptr;

    always_comb begin
        int idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_SRC;
            if (!sel_found && src_valid[idx]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_en) begin
            rr_ptr <= (sel_idx == IDX_W'(NUM_SRC - 1)) ? '0 : sel_idx + IDX_W'(1);
        end
    end
`else
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (src_valid[k]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(k);
            end
        end
    end
`endif

    always_comb begin
        ret_flit                             = '0;
        ret_flit[SRCID_LSB +: SRCID_W]       = SRCID_W'(SNF_NID_PARAM);
        ret_flit[OPCODE_LSB +: OPCODE_W]     = `CHIE_RESPLCRDRETURN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txrspflitv <= 1'b0;
            txrspflit  <= '0;
        end else begin
            txrspflitv <= flit_sent;
            if (grant_en) begin
                txrspflit <= src_flit[int'(sel_idx)*FW +: FW];
            end else if (ret_send) begin
                txrspflit <= ret_flit;
            end
        end
    end

    // Simultaneous receive and send leaves the count unchanged; overflow is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            txrsp_crd_ovf <= 1'b0;
        end else if (txrsp_lcrdv && !flit_sent) begin
            if (cnt == CNT_MAX) begin
                txrsp_crd_ovf <= 1'b1;
            end else begin
                cnt <= cnt + CRD_CNT_WIDTH'(1);
            end
        end else if (!txrsp_lcrdv && flit_sent) begin
            cnt <= cnt - CRD_CNT_WIDTH'(1);
        end
    end

endmodule

// File: doc/snf_txrsp_arb.md
# snf_txrsp_arb

Parametrised SNF TX response-channel link-layer sender. Arbitrates NUM_SRC pre-formed CHI-E RSP flit sources onto the single txrspflit interface, gated by a saturating L-credit counter. Adds a link-deactivation credit-return sequence that drains held credits as RespLCrdReturn flits. Sits between snf_qos/snf_mshr response producers and the snf_link TX RSP port.

## Interface
- NUM_SRC, 3, number of requesting sources; index 0 is highest fixed priority.
- CRD_MAX, 15, maximum L-credits the receiver may grant.
- CRD_CNT_WIDTH, 4, credit counter width; must hold CRD_MAX.
- SNF_NID_PARAM, 0, node ID placed in SRCID of generated RespLCrdReturn flits.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- txrsp_link_active  in  1  high while TX RSP channel is in RUN; low requests deactivation.
- txrsp_lcrdv  in  1  one L-credit received this cycle.
- src_valid  in  NUM_SRC  per-source flit request.
- src_flit  in  NUM_SRC*`CHIE_RSP_FLIT_WIDTH  per-source complete flit; source i at bits [i*W +: W].
- src_won  out  NUM_SRC  one-hot grant; flit accepted this cycle.
- txrspflitv  out  1  registered flit valid.
- txrspflit  out  `CHIE_RSP_FLIT_WIDTH  registered flit.
- txrspflitpend  out  1  tied 1.
- txrsp_stopped  out  1  high in STOP state.
- txrsp_crd_ovf  out  1  sticky: credit received while counter at CRD_MAX.

## Operation
- States: STOP (reset), RUN, RETURN.
- STOP -> RUN when txrsp_link_active=1. STOP with link_active=0 and txrsp_lcrdv=1 -> RETURN (stray credit counted, then returned).
- RUN -> RETURN when txrsp_link_active=0; a grant in that same cycle is not issued.
- RETURN -> STOP when credit count is 0 and txrsp_lcrdv=0. RETURN -> RUN is not allowed; link_active is ignored until STOP.
- crd_avail = txrsp_lcrdv | (cnt != 0).
- RUN: if any src_valid and crd_avail, exactly one src_won asserted; selected src_flit registered to txrspflit, txrspflitv=1 next cycle.
- RETURN: each cycle crd_avail, send flit with OPCODE=`CHIE_RESPLCRDRETURN, SRCID=SNF_NID_PARAM, all other fields 0; src_won all 0.
- Counter: inc = txrsp_lcrdv; dec = flit sent. inc&dec -> hold; inc only -> +1; dec only -> -1; neither -> hold.
- Saturation: inc only with cnt==CRD_MAX -> cnt holds, txrsp_crd_ovf set; cleared only by rst.
- Dec never occurs at cnt==0 without same-cycle lcrdv (guaranteed by crd_avail).
- txrspflit holds last value when txrspflitv=0.

## Timing
- Reset: state STOP, cnt 0, txrspflitv 0, txrspflit 0, txrsp_crd_ovf 0, txrsp_stopped 1, RR pointer 0.
- src_won combinational from src_valid, state, cnt, txrsp_lcrdv; same cycle.
- Flit latency: 1 cycle from won/return decision to txrspflitv.
- A credit arriving on txrsp_lcrdv is usable in the same cycle.
- Back-to-back flits every cycle while credits last; RETURN of N credits takes N cycles when no further lcrdv.
- Reset mid-RETURN: immediate STOP, count cleared, no further return flits.

## Configuration
- SNF_TXRSP_RR_EN defined: round-robin among sources; search starts at pointer, pointer <= grantee+1 (wrapping at NUM_SRC) on each grant, unchanged otherwise.
- Undefined: fixed priority, lowest index wins; no pointer logic.

## Test plan
- Reset, link_active=1, 3 lcrdv pulses, src_valid=3'b111 held -> 3 flits on consecutive cycles; fixed: src0,src0,src0; RR: src0,src1,src2; cnt ends 0.
- cnt=0, src_valid=3'b010 with lcrdv same cycle -> src_won=3'b010, txrspflitv next cycle, cnt stays 0.
- 16 lcrdv pulses, no requests, CRD_MAX=15 -> cnt=15, txrsp_crd_ovf=1 after 16th.
- cnt=4, drop link_active with src_valid=1 -> no src_won; 4 RespLCrdReturn flits SRCID=SNF_NID_PARAM; txrsp_stopped=1 next cycle after cnt 0.
- RETURN with cnt=2, lcrdv on first return cycle -> 3 return flits total before STOP.
- Assert rst during RETURN with cnt=5 -> txrspflitv=0, cnt 0, STOP next edge, no further flits.
